// File: rtl/menu_key_ctrl_if.sv
// Keyboard-strobe / menu-key bundle for menu_key_ctrl.
//   keyCode/make/brakee : scan code and press/release strobes from the decoder
//   *_key_pressed       : level, key held
//   *_pulse             : one-cycle press / auto-repeat event
//   any_key             : OR of the three held levels
// master drives the strobes (decoder side), slave is menu_key_ctrl.
interface menu_key_ctrl_if;
  logic [8:0] keyCode;
  logic       make;
  logic       brakee;
  logic       enter_key_pressed;
  logic       up_key_pressed;
  logic       down_key_pressed;
  logic       enter_pulse;
  logic       up_pulse;
  logic       down_pulse;
  logic       any_key;

  modport master (
    output keyCode, make, brakee,
    input  enter_key_pressed, up_key_pressed, down_key_pressed,
    input  enter_pulse, up_pulse, down_pulse, any_key
  );

  modport slave (
    input  keyCode, make, brakee,
    output enter_key_pressed, up_key_pressed, down_key_pressed,
    output enter_pulse, up_pulse, down_pulse, any_key
  );
endinterface

// File: rtl/menu_key_ctrl.sv
// Menu key controller: turns keyboard make/break strobes for Enter, Up and
// Down into held levels and one-cycle press pulses, with optional typematic
// auto-repeat on Up/Down.
//   clk    : system clock
//   resetN : asynchronous active-low reset
//   kb     : menu_key_ctrl_if.slave (strobes in, levels/pulses out)
// Build option: define KEY_AUTOREPEAT_EN to enable the REPEAT state and the
// hold counters; without it every key pulses once per press.
module menu_key_ctrl #(
  parameter logic [8:0]  ENTER_CODE   = 9'h05A,
  parameter logic [8:0]  UP_CODE      = 9'h175,
  parameter logic [8:0]  DOWN_CODE    = 9'h172,
  parameter int unsigned REPEAT_DELAY = 25_000_000,
  parameter int unsigned REPEAT_RATE  = 5_000_000
) (
  input  logic           clk,
  input  logic           resetN,
  menu_key_ctrl_if.slave kb
);

  localparam int unsigned NKEYS = 3;

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned            CNT_W      = 26;
  localparam logic [CNT_W-1:0]       DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0]       RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, PRESSED, HOLD_DELAY, REPEAT} state_t;
`else
  typedef enum logic [1:0] {IDLE, PRESSED, HOLD_DELAY} state_t;

  // delay/rate have no function without auto-repeat
  logic [31:0] w_unused_cfg;
  assign w_unused_cfg = 32'(REPEAT_DELAY ^ REPEAT_RATE);
`endif

  logic [NKEYS-1:0] w_pressed_nxt;
  logic [NKEYS-1:0] w_pressed_q;
  logic [NKEYS-1:0] w_pulse_q;
  logic             r_any;

  for (genvar k = 0; k < NKEYS; k++) begin : g_key
    localparam logic [8:0] KEY_CODE = (k == 0) ? ENTER_CODE :
                                      (k == 1) ? UP_CODE : DOWN_CODE;

    state_t r_state, w_state_nxt;
    logic   r_pulse, w_pulse_nxt;
    logic   r_pressed;
    logic   w_hit_make, w_hit_brk;

    assign w_hit_make = kb.make   && (kb.keyCode == KEY_CODE);
    assign w_hit_brk  = kb.brakee && (kb.keyCode == KEY_CODE);

`ifdef KEY_AUTOREPEAT_EN
    // Enter never repeats
    localparam bit CAN_REPEAT = (k != 0);

    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    // saturating increment
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
`endif

    // next-state / next-output; release beats press, repeated makes ignored
    always_comb begin
      w_state_nxt = r_state;
      w_pulse_nxt = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      w_cnt_nxt   = r_cnt;
`endif
      case (r_state)
        IDLE: begin
          if (w_hit_make && !w_hit_brk) begin
            w_state_nxt = PRESSED;
            w_pulse_nxt = 1'b1;
          end
        end
        PRESSED: begin
          if (w_hit_brk) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = HOLD_DELAY;
`ifdef KEY_AUTOREPEAT_EN
            w_cnt_nxt   = '0;
`endif
          end
        end
        HOLD_DELAY: begin
          if (w_hit_brk) begin
            w_state_nxt = IDLE;
          end
`ifdef KEY_AUTOREPEAT_EN
          else if (CAN_REPEAT && (r_cnt >= DELAY_LAST)) begin
            w_state_nxt = REPEAT;
            w_pulse_nxt = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
          end
`endif
        end
`ifdef KEY_AUTOREPEAT_EN
        REPEAT: begin
          if (w_hit_brk) begin
            w_state_nxt = IDLE;
          end else if (r_cnt >= RATE_LAST) begin
            w_pulse_nxt = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
          end
        end
`endif
        default: w_state_nxt = IDLE;
      endcase
    end

    assign w_pressed_nxt[k] = (w_state_nxt != IDLE);

    // state and registered outputs
    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        r_state   <= IDLE;
        r_pulse   <= 1'b0;
        r_pressed <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        r_cnt     <= '0;
`endif
      end else begin
        r_state   <= w_state_nxt;
        r_pulse   <= w_pulse_nxt;
        r_pressed <= w_pressed_nxt[k];
`ifdef KEY_AUTOREPEAT_EN
        r_cnt     <= w_cnt_nxt;
`endif
      end
    end

    assign w_pressed_q[k] = r_pressed;
    assign w_pulse_q[k]   = r_pulse;
  end

  // any_key registered from the next-state levels so it tracks them exactly
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_any <= 1'b0;
    else         r_any <= |w_pressed_nxt;
  end

  assign kb.enter_key_pressed = w_pressed_q[0];
  assign kb.up_key_pressed    = w_pressed_q[1];
  assign kb.down_key_pressed  = w_pressed_q[2];
  assign kb.enter_pulse       = w_pulse_q[0];
  assign kb.up_pulse          = w_pulse_q[1];
  assign kb.down_pulse        = w_pulse_q[2];
  assign kb.any_key           = r_any;

endmodule

// File: tb/tb_menu_key_ctrl.sv
// Scoreboard bench for menu_key_ctrl (REPEAT_DELAY=8, REPEAT_RATE=4).
// Stimulus pushes expected pulse cycles and expected levels; a monitor on the
// falling edge pops and compares.
module tb_menu_key_ctrl;
  localparam logic [8:0] ENTER = 9'h05A;
  localparam logic [8:0] UP    = 9'h175;
  localparam logic [8:0] DOWN  = 9'h172;

  typedef struct {int cyc; int key; logic exp;} lvl_t;

  logic clk = 1'b0;
  logic resetN;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  bit   done = 1'b0;
  bit   fin = 1'b0;

  int   pq[3][$];
  lvl_t lvl_q[$];

  menu_key_ctrl_if bus();

  menu_key_ctrl #(.REPEAT_DELAY(8), .REPEAT_RATE(4)) dut (
    .clk    (clk),
    .resetN (resetN),
    .kb     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] w_lvl;
  logic [2:0] w_pul;
  assign w_lvl = {bus.any_key, bus.down_key_pressed, bus.up_key_pressed, bus.enter_key_pressed};
  assign w_pul = {bus.down_pulse, bus.up_pulse, bus.enter_pulse};

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [8:0] code, input logic mk, input logic brk, output int t);
    bus.keyCode = code;
    bus.make    = mk;
    bus.brakee  = brk;
    t = cyc;
    tick(1);
    bus.make   = 1'b0;
    bus.brakee = 1'b0;
  endtask

  task automatic exp_lvl(input int c, input int k, input logic e);
    lvl_t x;
    x.cyc = c; x.key = k; x.exp = e;
    lvl_q.push_back(x);
  endtask

  // monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        while (pq[k].size() > 0 && pq[k][0] < cyc) begin
          n_chk++;
          $display("FAIL pulse%0d_missed: got none, required at cycle %0d", k, pq[k][0]);
          void'(pq[k].pop_front());
        end
        if (w_pul[k]) begin
          n_chk++;
          if (pq[k].size() > 0 && pq[k][0] == cyc) begin
            n_pass++;
            void'(pq[k].pop_front());
          end else begin
            $display("FAIL pulse%0d_extra: got pulse at cycle %0d, required none", k, cyc);
          end
        end
      end
      while (lvl_q.size() > 0 && lvl_q[0].cyc <= cyc) begin
        n_chk++;
        if (lvl_q[0].cyc < cyc)
          $display("FAIL level%0d_stale: check for cycle %0d not reached", lvl_q[0].key, lvl_q[0].cyc);
        else if (w_lvl[lvl_q[0].key] !== lvl_q[0].exp)
          $display("FAIL level%0d cycle %0d: got %b, required %b",
                   lvl_q[0].key, cyc, w_lvl[lvl_q[0].key], lvl_q[0].exp);
        else
          n_pass++;
        void'(lvl_q.pop_front());
      end
      if (done && !fin) begin
        for (int k = 0; k < 3; k++) begin
          n_chk++;
          if (pq[k].size() == 0) n_pass++;
          else $display("FAIL pulse%0d_drain: got %0d outstanding, required 0", k, pq[k].size());
        end
        n_chk++;
        if (lvl_q.size() == 0) n_pass++;
        else $display("FAIL level_drain: got %0d outstanding, required 0", lvl_q.size());
        fin = 1'b1;
      end
    end
  end

  initial begin
    int t, t2, tx;
    resetN      = 1'b0;
    bus.keyCode = '0;
    bus.make    = 1'b0;
    bus.brakee  = 1'b0;
    for (int k = 0; k < 4; k++) exp_lvl(1, k, 1'b0);
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;
    tick(1);

    // Enter: one pulse, never repeats, level until release
    drive(ENTER, 1'b1, 1'b0, t);
    pq[0].push_back(t + 1);
    exp_lvl(t + 1, 0, 1'b1); exp_lvl(t + 1, 3, 1'b1); exp_lvl(t + 5, 0, 1'b1);
    tick(19);
    drive(ENTER, 1'b0, 1'b1, t2);
    exp_lvl(t + 21, 0, 1'b0); exp_lvl(t + 21, 3, 1'b0);
    tick(12);

    // Up: press, hold, release
    drive(UP, 1'b1, 1'b0, t);
    pq[1].push_back(t + 1);
    exp_lvl(t + 1, 1, 1'b1);
`ifdef KEY_AUTOREPEAT_EN
    pq[1].push_back(t + 10); pq[1].push_back(t + 14);
    tick(15);
    drive(UP, 1'b0, 1'b1, t2);
    exp_lvl(t + 17, 1, 1'b0); exp_lvl(t + 17, 3, 1'b0);
`else
    tick(49);
    exp_lvl(t + 50, 1, 1'b1);
    drive(UP, 1'b0, 1'b1, t2);
    exp_lvl(t + 51, 1, 1'b0); exp_lvl(t + 51, 3, 1'b0);
`endif
    tick(10);

    // make+brakee together, idle release, non-matching code (ext bit clear)
    drive(DOWN, 1'b1, 1'b1, t);
    exp_lvl(t + 1, 2, 1'b0); exp_lvl(t + 2, 2, 1'b0);
    drive(UP, 1'b0, 1'b1, t);
    exp_lvl(t + 1, 1, 1'b0);
    drive(9'h075, 1'b1, 1'b0, t);
    exp_lvl(t + 1, 1, 1'b0); exp_lvl(t + 1, 3, 1'b0);
    tick(12);

    // Down with typematic makes every 3 cycles
    drive(DOWN, 1'b1, 1'b0, t);
    pq[2].push_back(t + 1);
`ifdef KEY_AUTOREPEAT_EN
    pq[2].push_back(t + 10); pq[2].push_back(t + 14);
`endif
    for (int i = 0; i < 5; i++) begin
      tick(2);
      drive(DOWN, 1'b1, 1'b0, tx);
    end
    exp_lvl(t + 16, 2, 1'b1);
    drive(DOWN, 1'b0, 1'b1, t2);
    exp_lvl(t + 17, 2, 1'b0);
    tick(10);

    // Up and Down held together, independent schedules
    drive(UP, 1'b1, 1'b0, t);
    pq[1].push_back(t + 1);
    tick(1);
    drive(DOWN, 1'b1, 1'b0, t2);
    pq[2].push_back(t + 3);
`ifdef KEY_AUTOREPEAT_EN
    pq[1].push_back(t + 10); pq[1].push_back(t + 14); pq[1].push_back(t + 18);
    pq[2].push_back(t + 12); pq[2].push_back(t + 16); pq[2].push_back(t + 20);
`endif
    tick(18);
    drive(UP, 1'b0, 1'b1, t2);
    exp_lvl(t + 22, 1, 1'b0); exp_lvl(t + 22, 2, 1'b1); exp_lvl(t + 22, 3, 1'b1);
    drive(DOWN, 1'b0, 1'b1, t2);
    exp_lvl(t + 23, 2, 1'b0); exp_lvl(t + 23, 3, 1'b0);
    tick(10);

    // reset while Up is held
    drive(UP, 1'b1, 1'b0, t);
    pq[1].push_back(t + 1);
`ifdef KEY_AUTOREPEAT_EN
    pq[1].push_back(t + 10);
`endif
    tick(11);
    resetN = 1'b0;
    for (int k = 0; k < 4; k++) exp_lvl(t + 12, k, 1'b0);
    tick(2);
    resetN = 1'b1;
    tick(20);
    exp_lvl(t + 34, 1, 1'b0); exp_lvl(t + 34, 3, 1'b0);
    tick(1);

    // fresh press after reset
    drive(UP, 1'b1, 1'b0, t);
    pq[1].push_back(t + 1);
    exp_lvl(t + 1, 1, 1'b1);
    tick(2);
    drive(UP, 1'b0, 1'b1, t2);
    exp_lvl(t + 4, 1, 1'b0);
    tick(5);

    done = 1'b1;
    for (int i = 0; i < 10 && !fin; i++) @(negedge clk);
    #1;
    if (!fin) begin
      $display("FAIL monitor_timeout: got no drain, required drain");
      $fatal(1, "monitor did not finish");
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
